// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared fp32 constants and the multiplier result record. The multiplier
// wrapper and the writeback buffer both import this package.
//   FP32_EXP_W / FP32_MAN_W : exponent and mantissa field widths
//   FP32_*_MSB / *_LSB      : bit positions for slicing an fp32 word
//   fmul_res_t              : {tag, d, overflow, underflow} from the multiplier
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
  localparam int FP32_W     = 1 + FP32_EXP_W + FP32_MAN_W;

  localparam int FP32_SIGN_BIT = FP32_W - 1;
  localparam int FP32_EXP_MSB  = FP32_W - 2;
  localparam int FP32_EXP_LSB  = FP32_MAN_W;
  localparam int FP32_MAN_MSB  = FP32_MAN_W - 1;
  localparam int FP32_MAN_LSB  = 0;

  // Default destination-register index width of the FP register file.
  localparam int FMUL_TAG_W = 5;

  typedef struct packed {
    logic [FMUL_TAG_W-1:0] tag;
    logic [FP32_W-1:0]     d;
    logic                  overflow;
    logic                  underflow;
  } fmul_res_t;

endpackage

// File: rtl/fmul_wb_buffer_if.sv
// -----------------------------------------------------------------------------
// fmul_wb_buffer_if
// Handshake bundle between the fp32 multiplier, the writeback buffer and the
// FP register-file writeback port.
//   in_*  : multiplier result (valid/ready, tag, product, exception flags)
//   out_* : head of the buffer toward writeback (valid/ready, tag, product)
// Modports:
//   master : the surrounding pipeline (drives in_* payload and out_ready)
//   slave  : the buffer (drives in_ready and out_* payload)
// -----------------------------------------------------------------------------
interface fmul_wb_buffer_if
  import fpu_pkg::*;
#(
  parameter int TAG_W = 5
);

  logic              in_valid;
  logic              in_ready;
  logic [TAG_W-1:0]  in_tag;
  logic [FP32_W-1:0] in_d;
  logic              in_overflow;
  logic              in_underflow;

  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [FP32_W-1:0] out_d;

  modport master (
    output in_valid, in_tag, in_d, in_overflow, in_underflow, out_ready,
    input  in_ready, out_valid, out_tag, out_d
  );

  modport slave (
    input  in_valid, in_tag, in_d, in_overflow, in_underflow, out_ready,
    output in_ready, out_valid, out_tag, out_d
  );

endinterface

// File: rtl/fpu_sync_fifo.sv
// -----------------------------------------------------------------------------
// fpu_sync_fifo
// Generic single-clock register-array FIFO. DEPTH must be a power of two
// (minimum 2) so the pointers wrap naturally.
//   clk, rst : clock, synchronous active-high reset
//   push     : write wr_data (ignored while full, no push-through)
//   pop      : retire the head entry (ignored while empty)
//   rd_data  : head entry
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : current occupancy
// -----------------------------------------------------------------------------
module fpu_sync_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // NOTE: the storage array has no reset; occupancy is tracked by count, so
  // stale contents are never presented and a reset net on the array is wasted.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fmul_wb_buffer.sv
// -----------------------------------------------------------------------------
// fmul_wb_buffer
// Writeback buffer behind the fp32 multiplier. Queues {tag, product} in a
// small FIFO, releases them to the FP register-file writeback port under
// valid/ready, and keeps sticky overflow/underflow flags for the FP status
// register.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : fmul_wb_buffer_if.slave (in_* from multiplier, out_* to WB)
//   flags_clr : clear both sticky flags (a same-cycle flagged push wins)
//   flag_of   : sticky overflow
//   flag_uf   : sticky underflow
//   count     : current occupancy
// Build option:
//   FMUL_WB_BYPASS_EN : an empty buffer with out_ready high forwards the
//                       input combinationally to out_* without storing it.
// -----------------------------------------------------------------------------
module fmul_wb_buffer
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  fmul_wb_buffer_if.slave            bus,
  input  logic                       flags_clr,
  output logic                       flag_of,
  output logic                       flag_uf,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int ENTRY_W = TAG_W + FP32_W;

  logic               full;
  logic               empty;
  logic               accept;
  logic               fifo_push;
  logic [ENTRY_W-1:0] head;
  logic [TAG_W-1:0]   head_tag;
  logic [FP32_W-1:0]  head_d;

  assign bus.in_ready = !full;
  assign accept       = bus.in_valid && !full;
  assign {head_tag, head_d} = head;

`ifdef FMUL_WB_BYPASS_EN
  // Forward only when nothing is queued, so ordering is preserved.
  logic bypass;
  assign bypass        = empty && bus.in_valid && bus.out_ready;
  assign fifo_push     = accept && !bypass;
  assign bus.out_valid = !empty || bypass;
  assign bus.out_tag   = bypass ? bus.in_tag : head_tag;
  assign bus.out_d     = bypass ? bus.in_d   : head_d;
`else
  assign fifo_push     = accept;
  assign bus.out_valid = !empty;
  assign bus.out_tag   = head_tag;
  assign bus.out_d     = head_d;
`endif

  fpu_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data ({bus.in_tag, bus.in_d}),
    .pop     (bus.out_ready),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // Sticky flags follow accepted inputs, including bypassed ones. The clear
  // drops the old value only, so an event arriving with it is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      flag_of <= 1'b0;
      flag_uf <= 1'b0;
    end else begin
      flag_of <= (flag_of && !flags_clr) || (accept && bus.in_overflow);
      flag_uf <= (flag_uf && !flags_clr) || (accept && bus.in_underflow);
    end
  end

endmodule

// File: tb/tb_fmul_wb_buffer.sv
// -----------------------------------------------------------------------------
// tb_fmul_wb_buffer
// Scoreboard bench for fmul_wb_buffer. Stimulus pushes the expected {tag, d}
// whenever an input will be accepted; a negedge monitor pops and compares
// each time the DUT hands an entry to writeback. Build with
// +define+FMUL_WB_BYPASS_EN to exercise the bypass variant.
// -----------------------------------------------------------------------------
module tb_fmul_wb_buffer;

  localparam int DEPTH = 4;
  localparam int TAG_W = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       flags_clr;
  logic       flag_of;
  logic       flag_uf;
  logic [2:0] count;

  int errors = 0;
  int checks = 0;

  logic [TAG_W+31:0] sb[$];

  fmul_wb_buffer_if #(.TAG_W(TAG_W)) bus ();

  fmul_wb_buffer #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .flags_clr (flags_clr),
    .flag_of   (flag_of),
    .flag_uf   (flag_uf),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got tag=%0d d=%h with nothing expected", bus.out_tag, bus.out_d);
      end else begin
        logic [TAG_W+31:0] exp;
        exp = sb.pop_front();
        check("out_tag", 64'(bus.out_tag), 64'(exp[TAG_W+31:32]));
        check("out_d",   64'(bus.out_d),   64'(exp[31:0]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a result; record it as expected only if it will be accepted.
  task automatic drive(input logic [TAG_W-1:0] tag, input logic [31:0] d,
                       input logic of, input logic uf);
    bus.in_valid     = 1'b1;
    bus.in_tag       = tag;
    bus.in_d         = d;
    bus.in_overflow  = of;
    bus.in_underflow = uf;
    if (bus.in_ready) sb.push_back({tag, d});
  endtask

  task automatic idle();
    bus.in_valid     = 1'b0;
    bus.in_overflow  = 1'b0;
    bus.in_underflow = 1'b0;
  endtask

  task automatic issue(input logic [TAG_W-1:0] tag, input logic [31:0] d,
                       input logic of, input logic uf);
    drive(tag, d, of, uf);
    tick();
    idle();
  endtask

  initial begin
    logic [31:0] vals [4];
    logic [31:0] vals2 [4];
    vals  = '{32'h3f800000, 32'h40000000, 32'h40400000, 32'h40800000};
    vals2 = '{32'h40e00000, 32'h41000000, 32'h41100000, 32'h41200000};

    rst = 1'b1;
    flags_clr = 1'b0;
    bus.in_tag = '0;
    bus.in_d = '0;
    bus.out_ready = 1'b0;
    idle();
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_count",     64'(count), 64'd0);
    check("rst_in_ready",  64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_flag_of",   64'(flag_of), 64'd0);
    check("rst_flag_uf",   64'(flag_uf), 64'd0);

    // Single push with writeback ready
    bus.out_ready = 1'b1;
    issue(5'd3, 32'h40400000, 1'b0, 1'b0);
`ifdef FMUL_WB_BYPASS_EN
    check("t1_count_after_push", 64'(count), 64'd0);
`else
    check("t1_count_after_push", 64'(count), 64'd1);
    check("t1_out_valid",        64'(bus.out_valid), 64'd1);
`endif
    tick();
    check("t1_count_drained", 64'(count), 64'd0);
    check("t1_flag_of",       64'(flag_of), 64'd0);
    check("t1_flag_uf",       64'(flag_uf), 64'd0);

    // Fill to DEPTH with writeback stalled
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(5'(i + 1), vals[i], 1'b0, 1'b0);
    check("t2_count_full", 64'(count), 64'd4);
    check("t2_in_ready",   64'(bus.in_ready), 64'd0);
    tick();
    tick();
    check("t2_head_tag_stable", 64'(bus.out_tag), 64'd1);
    check("t2_head_d_stable",   64'(bus.out_d), 64'h3f800000);
    // Rejected input must neither enqueue nor set a flag
    issue(5'd7, 32'h40a00000, 1'b1, 1'b0);
    check("t2_reject_count", 64'(count), 64'd4);
    check("t2_reject_of",    64'(flag_of), 64'd0);

    // Full with push and pop in the same cycle: only the pop happens
    drive(5'd8, 32'h40c00000, 1'b0, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    idle();
    check("t3_count", 64'(count), 64'd3);
    check("t3_reject_uf", 64'(flag_uf), 64'd0);
    check("t3_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) tick();
    check("t3_drained", 64'(count), 64'd0);

    // Second fill crosses the pointer wrap again
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(5'(i + 9), vals2[i], 1'b0, 1'b0);
    check("t2_wrap_count", 64'(count), 64'd4);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    check("t2_wrap_drained", 64'(count), 64'd0);

    // Sticky flags
    issue(5'd13, 32'h3f800000, 1'b1, 1'b0);
    issue(5'd14, 32'h40000000, 1'b0, 1'b1);
    check("t4_flag_of", 64'(flag_of), 64'd1);
    check("t4_flag_uf", 64'(flag_uf), 64'd1);
    tick();
    check("t4_flags_hold_over_pops", 64'({flag_of, flag_uf}), 64'b11);
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("t4_clr_of", 64'(flag_of), 64'd0);
    check("t4_clr_uf", 64'(flag_uf), 64'd0);

    // Clear and flagged push together: the new event survives
    flags_clr = 1'b1;
    drive(5'd15, 32'h40400000, 1'b1, 1'b0);
    tick();
    idle();
    flags_clr = 1'b0;
    check("t5_of_set_wins", 64'(flag_of), 64'd1);
    check("t5_uf_clear",    64'(flag_uf), 64'd0);
    repeat (2) tick();
    check("t5_drained", 64'(count), 64'd0);

    // Reset mid-operation
    bus.out_ready = 1'b0;
    issue(5'd16, 32'h3f800000, 1'b0, 1'b1);
    issue(5'd17, 32'h40000000, 1'b0, 1'b0);
    check("t6_count_before", 64'(count), 64'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    check("t6_out_valid", 64'(bus.out_valid), 64'd0);
    check("t6_count",     64'(count), 64'd0);
    check("t6_flags",     64'({flag_of, flag_uf}), 64'd0);
    check("t6_in_ready",  64'(bus.in_ready), 64'd1);

    // Same-cycle visibility on an empty buffer
    bus.out_ready = 1'b1;
    drive(5'd18, 32'hbf800000, 1'b0, 1'b0);
    #1;
`ifdef FMUL_WB_BYPASS_EN
    check("t7_bypass_valid", 64'(bus.out_valid), 64'd1);
    check("t7_bypass_d",     64'(bus.out_d), 64'hbf800000);
    check("t7_bypass_count", 64'(count), 64'd0);
`else
    check("t7_no_bypass_valid", 64'(bus.out_valid), 64'd0);
`endif
    tick();
    idle();
`ifdef FMUL_WB_BYPASS_EN
    check("t7_next_count", 64'(count), 64'd0);
    check("t7_next_valid", 64'(bus.out_valid), 64'd0);
`else
    check("t7_next_valid", 64'(bus.out_valid), 64'd1);
    check("t7_next_d",     64'(bus.out_d), 64'hbf800000);
`endif
    tick();
    check("t7_drained", 64'(count), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
